// File: rtl/fir_xifu_wb.sv
`default_nettype none
// ============================================================================
// Module   : fir_xifu_wb
// Purpose  : FIR XIFU writeback stage - internal regfile write port plus a
//            small result FIFO returning one CV-X-IF result per instruction.
// Revision : 1.0 - initial release
// ============================================================================
module fir_xifu_wb #(
    parameter int NB_REGS    = 4,
    parameter int X_ID_WIDTH = 4,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       ex_valid_i,
    output logic                       ex_ready_o,
    input  logic [X_ID_WIDTH-1:0]      ex_id_i,
    input  logic [4:0]                 ex_rd_i,
    input  logic [31:0]                ex_result_i,
    input  logic                       ex_we_xrf_i,
    input  logic                       ex_we_int_i,
    output logic                       rf_write_o,
    output logic [$clog2(NB_REGS)-1:0] rf_rd_o,
    output logic [31:0]                rf_result_o,
    output logic                       x_result_valid_o,
    input  logic                       x_result_ready_i,
    output logic [X_ID_WIDTH-1:0]      x_result_id_o,
    output logic [31:0]                x_result_data_o,
    output logic [4:0]                 x_result_rd_o,
    output logic                       x_result_we_o,
    output logic                       busy_o
);

    localparam int c_RF_AW = $clog2(NB_REGS);
    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_ENT_W = X_ID_WIDTH + 5 + 32 + 1;

    logic [c_ENT_W-1:0] r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wptr;
    logic [c_PTR_W-1:0] r_rptr;
    logic [c_CNT_W-1:0] r_count;

    logic               r_rf_write;
    logic [c_RF_AW-1:0] r_rf_rd;
    logic [31:0]        r_rf_result;

    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic [c_ENT_W-1:0] w_head;

    // Full comes only from the registered count, so a pop never frees a slot
    // for a push in the same cycle and ready_i has no path to ex_ready_o.
    assign w_full  = (r_count == c_CNT_W'(FIFO_DEPTH));
    assign w_empty = (r_count == '0);
    assign w_push  = ex_valid_i & ~w_full;
    assign w_pop   = ~w_empty & x_result_ready_i;
    assign w_head  = r_mem[r_rptr];

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wptr] <= {ex_id_i, ex_rd_i, ex_result_i, ex_we_xrf_i};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rf_write  <= 1'b0;
            r_rf_rd     <= '0;
            r_rf_result <= '0;
        end else begin
            r_rf_write <= w_push & ex_we_int_i;
            if (w_push & ex_we_int_i) begin
                r_rf_rd     <= ex_rd_i[c_RF_AW-1:0];
                r_rf_result <= ex_result_i;
            end
        end
    end

    // Result fields are forced to zero while empty so reset shows all-zero
    // outputs without needing a reset on the storage array.
    assign {x_result_id_o, x_result_rd_o, x_result_data_o, x_result_we_o} =
        w_empty ? '0 : w_head;

    assign x_result_valid_o = ~w_empty;
    assign ex_ready_o       = ~w_full;
    assign rf_write_o       = r_rf_write;
    assign rf_rd_o          = r_rf_rd;
    assign rf_result_o      = r_rf_result;
    assign busy_o           = ~w_empty | r_rf_write;

endmodule
`default_nettype wire

// File: doc/fir_xifu_wb.md
Name: fir_xifu_wb

Overview:
- Writeback stage of the FIR XIFU coprocessor pipeline. Accepts completed instructions from EX.
- Produces the single write port into the XIFU internal register file.
- Returns one CV-X-IF result per accepted instruction to the host core through a small result FIFO. The FIFO absorbs result-channel backpressure and throttles EX via ex_ready_o.

Parameters:
- NB_REGS, 4: internal register count; the rf_rd_o width is $clog2(NB_REGS).
- X_ID_WIDTH, 4: CV-X-IF instruction id width.
- FIFO_DEPTH, 2: result FIFO entries; power of two, >= 2.

Ports:
- clk_i  in  1  clock, all state updates on rising edge.
- rst_i  in  1  asynchronous reset, active-high.
- ex_valid_i  in  1  EX presents a completed instruction.
- ex_ready_o  out  1  WB can accept this cycle.
- ex_id_i  in  X_ID_WIDTH  instruction id.
- ex_rd_i  in  5  destination register index (core GPR or internal).
- ex_result_i  in  32  result value.
- ex_we_xrf_i  in  1  result is written to the core GPR rd.
- ex_we_int_i  in  1  result is written to internal register rd[$clog2(NB_REGS)-1:0].
- rf_write_o  out  1  internal regfile write enable.
- rf_rd_o  out  $clog2(NB_REGS)  internal regfile write index.
- rf_result_o  out  32  internal regfile write data.
- x_result_valid_o  out  1  CV-X-IF result valid.
- x_result_ready_i  in  1  CV-X-IF result ready.
- x_result_id_o  out  X_ID_WIDTH  result id.
- x_result_data_o  out  32  result data.
- x_result_rd_o  out  5  result rd.
- x_result_we_o  out  1  core GPR write enable for this result.
- busy_o  out  1  FIFO non-empty or internal write pending.

Behaviour:
- Accept: an instruction is accepted when ex_valid_i & ex_ready_o.
- ex_ready_o = ~full, driven from the registered FIFO count only. There is no combinational path from x_result_ready_i to ex_ready_o. When full, a pop in the same cycle does not enable a push.
- Internal write path: rf_write_o/rf_rd_o/rf_result_o are registered. They assert for exactly one cycle, the cycle after acceptance, when ex_we_int_i was 1. rf_rd_o carries ex_rd_i truncated to its low bits. When no write is pending, rf_write_o=0 and rf_rd_o/rf_result_o hold their previous values.
- The internal write is independent of result-channel backpressure and is never delayed by the FIFO.
- Result path:
  - Every accepted instruction pushes exactly one entry {id, rd, result, we_xrf}, including instructions with ex_we_xrf_i=0. Those produce a result with x_result_we_o=0.
  - x_result_valid_o = ~empty; x_result_* reflect the FIFO head.
  - Earliest visibility is the cycle after acceptance, so minimum latency is 1 cycle.
- Handshake: a pop occurs on x_result_valid_o & x_result_ready_i. While valid is high and ready is low, all x_result_* outputs are held stable. Valid never drops without a pop.
- Ordering: results leave in acceptance order (FIFO).
- Simultaneous push and pop when not full and not empty: count is unchanged, pointers both advance.
- Push into an empty FIFO: the entry becomes visible the next cycle. There is no same-cycle fall-through.
- Pointers wrap modulo FIFO_DEPTH. Count is held in $clog2(FIFO_DEPTH)+1 bits.
- ex_we_int_i and ex_we_xrf_i both set: both paths are taken.
- busy_o = ~empty | rf_write_o.
- Reset (asserted at any time, including mid-transfer):
  - FIFO emptied; pointers and count cleared.
  - All outputs 0: x_result_valid_o=0, x_result_id/data/rd/we=0, rf_write_o=0, rf_rd_o=0, rf_result_o=0, busy_o=0.
  - ex_ready_o=1 once reset is released. In-flight results are discarded.

Test Plan:
- Single int write: accept {id=3, rd=2, result=0xDEADBEEF, we_int=1, we_xrf=0} with ready_i=1 -> next cycle rf_write_o=1, rf_rd_o=2, rf_result_o=0xDEADBEEF for one cycle, and x_result_valid_o=1 with id=3, we=0. The cycle after that, valid=0.
- Backpressure fill: x_result_ready_i=0, push ids 1 and 2 back-to-back -> ex_ready_o=0 after the second push. Head holds id=1, data stable for 5 cycles. Raise ready -> id 1 then id 2 in order, then ex_ready_o=1.
- Full plus pop same cycle: FIFO full, ex_valid_i=1, ready_i=1 -> exactly one pop, no push that cycle. Push accepted the following cycle. Count goes 2->1->2.
- Streaming: ready_i=1, valid every cycle for 8 ids 0..7 with result=id*0x11 -> zero stalls. Results emerge in order, each one cycle after acceptance.
- Dual write: we_int=1, we_xrf=1, rd=5, result=0x1234 -> rf_write_o with rf_rd_o=1, and x_result with rd=5, we=1, data=0x1234.
- Reset mid-operation: assert rst_i with 2 entries queued and ready_i=0 -> x_result_valid_o=0 and rf_write_o=0 immediately (asynchronous). After release, ex_ready_o=1, busy_o=0, and no stale result is emitted.
